// File: rtl/dbus_uart.sv
// dbus_uart: dbus-attached UART transmitter. A small byte FIFO feeds an 8N1
// framer whose bit time is set by a programmable clock divisor.
module dbus_uart #(
  parameter int          DW         = 16,
  parameter logic [15:0] DIV_RST    = 16'd16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          we,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          txd,
  output logic          irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   bit_div_q, bit_div_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic        wr_acc, wr_data, full, empty, busy, push, pop;
  logic [15:0] status;

  // Bus access: sel qualifies everything; writes commit on the rising edge,
  // reads are purely combinational and have no side effects.
  always_comb begin
    wr_acc  = sel & we;
    wr_data = wr_acc && (addr == 2'd0);
    full    = (level_q == LW'(FIFO_DEPTH));
    empty   = (level_q == '0);
    busy    = (state_q != S_IDLE);
    pop     = (state_q == S_IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push    = wr_data && (!full || pop);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    if (push) begin
      mem_d[wr_ptr_q] = din[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (wr_data && !push) ovf_d = 1'b1;
    if (wr_acc && (addr == 2'd1) && din[3]) ovf_d = 1'b0;
    if (wr_acc && (addr == 2'd2)) div_d = (din[15:0] == 16'd0) ? 16'd1 : din[15:0];
  end

  // Every phase (start, each data bit, stop) lasts bit_div clocks: the
  // down-counter is loaded with bit_div-1 and the phase ends when it hits 0.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_div_d = bit_div_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_div_d = div_q;
          cnt_d     = div_q - 16'd1;
          bit_cnt_d = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = bit_div_q - 16'd1;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = bit_div_q - 16'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'd0) state_d = S_IDLE;
        else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_div_q <= '0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      div_q     <= DIV_RST;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_div_q <= bit_div_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    status = {9'd0, 3'(level_q), ovf_q, busy, empty, full};
    dout   = '0;
    if (sel && !we) begin
      case (addr)
        2'd1:    dout = DW'(status);
        2'd2:    dout = DW'(div_q);
        default: dout = '0;
      endcase
    end
    irq = empty && (state_q == S_IDLE);
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: doc/dbus_uart.md
DBUS_UART -- requirements
Module: dbus_uart

Interface — parameters
REQ-001 DW, 16, data bus width; register read/write data width.
REQ-002 DIV_RST, 16'd16, reset value of the baud divisor register.
REQ-003 FIFO_DEPTH, 4, transmit FIFO entries (power of two, 8 bits each).

Interface — ports
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sel  input  1  slave select from dbus address decode; register access qualified by sel.
REQ-007 we  input  1  write enable, meaningful only when sel=1.
REQ-008 addr  input  2  register offset: 0 DATA, 1 STATUS, 2 DIV, 3 reserved.
REQ-009 din  input  DW  write data from dbus.
REQ-010 dout  output  DW  read data to dbus, combinational from sel/addr/state.
REQ-011 txd  output  1  UART serial output, idle high.
REQ-012 irq  output  1  high while FIFO empty and FSM in IDLE (transmitter drained).

Function — register access
REQ-013 Write DATA (sel&we, addr=0): push din[7:0] into FIFO if not full; if full, drop write and set sticky ovf.
REQ-014 Write STATUS: din[3]=1 clears ovf; other bits ignored.
REQ-015 Write DIV: load din[15:0] into div; value 0 treated as 1.
REQ-016 Write to addr 3 has no effect.
REQ-017 Read STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 ovf, bits[6:4] FIFO level 0..4, bits[15:7]=0.
REQ-018 Read DATA returns 0; read DIV returns div; read addr 3 returns 0.
REQ-019 dout = 0 whenever sel=0 or we=1.

Function — FIFO
REQ-020 Circular buffer, wrap-around read/write pointers, level counter 0..FIFO_DEPTH.
REQ-021 Push and pop in the same cycle: level unchanged; if full, the push is accepted because the pop frees a slot (no ovf).
REQ-022 Pop on empty never occurs; FSM only pops when level≠0.

Function — transmit FSM
REQ-023 States IDLE, START, DATA, STOP; txd=1 in IDLE and STOP, 0 in START, shift[0] in DATA.
REQ-024 IDLE: when level≠0, pop head into shift register, latch div into bit_div, clear bit counter, go START next cycle.
REQ-025 Each of START, each DATA bit, STOP lasts exactly bit_div clocks, timed by a down-counter.
REQ-026 DATA: 8 bits, LSB first; shift right at each bit boundary; after bit 7 go STOP.
REQ-027 STOP → IDLE after bit_div clocks; IDLE re-evaluates FIFO same cycle, so back-to-back frames have one idle-high clock between stop and next start.
REQ-028 DIV writes during a frame do not affect that frame; take effect at next frame start.
REQ-029 Frame length: 10×bit_div clocks from first START clock to last STOP clock.

Reset
REQ-030 On rst assertion, immediately and independent of clk: FSM=IDLE, txd=1, FIFO empty (level 0, pointers 0), ovf=0, div=DIV_RST, shift=0, counters 0, irq=1.
REQ-031 Reset mid-frame aborts the frame; txd returns high asynchronously; FIFO contents discarded.
REQ-032 After rst deasserts, first accepted write may occur on the next rising edge.

Verification
REQ-033 Reset then read STATUS, DIV -> STATUS=0x0002, DIV=0x0010, txd=1, irq=1.
REQ-034 Write DIV=4, write DATA=0x55 -> txd low 4 clks, then 1,0,1,0,1,0,1,0 each 4 clks, high 4 clks; busy=1 for 40 clks; irq=1 after.
REQ-035 DIV=4; write DATA 0x01..0x05 on 5 consecutive cycles -> STATUS level=4, full=1, ovf=0; 6th write 0x06 -> ovf=1, 0x06 never transmitted; 0x01..0x05 sent in order with 1 idle clk between frames.
REQ-036 Write STATUS din=0x0008 with ovf=1 -> ovf=0; other status bits unchanged.
REQ-037 DIV=8, start 0xA3, write DIV=2 mid-frame -> current frame keeps 8-clk bits; next queued frame uses 2-clk bits.
REQ-038 Assert rst during DATA of a frame with 2 bytes queued -> txd=1 without clock edge; after release STATUS=0x0002, no further transmission.
